mem_bus_arbiter: RTL and testbench

Two-requester memory bus arbiter sitting between the requesters and the single memory port of `mmu`. Requester 0 is `vproc_top` (core/vector unit). Requester 1 is the programming/debug loader driven over external SPI. It grants one request per cycle to the downstream port and tracks up to `MAX_OUTST` outstanding transactions in an ID FIFO, so in-order responses return to the requester that issued them. `set_programming_mode` and `set_debug_mode` select the arbitration policy.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_bus_arbiter_id_fifo.sv | 55 +++++
 rtl/mem_bus_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_bus_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-requester memory bus arbiter: requester IDs,
// arbitration modes and the default outstanding-transaction depth.
package mem_arb_pkg;

    typedef enum logic {REQ_VPROC = 1'b0, REQ_PROG = 1'b1} req_id_e;

    typedef enum logic [1:0] {ARB_RR, ARB_DEBUG, ARB_PROG} arb_mode_e;

    localparam int unsigned MAX_OUTST_DEF = 4;

    // Programming mode outranks debug mode; both outrank round-robin.
    function automatic arb_mode_e arb_mode(input logic prog, input logic dbg);
        if (prog) return ARB_PROG;
        if (dbg)  return ARB_DEBUG;
        return ARB_RR;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_id_fifo.sv
// FIFO of requester IDs for in-flight downstream transactions; the head entry
// names the requester that owns the next in-order response.
module id_fifo
    import mem_arb_pkg::*;
#(
    parameter int unsigned DEPTH = MAX_OUTST_DEF
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  req_id_e push_id,
    input  logic    pop,
    output req_id_e pop_id,
    output logic    full,
    output logic    empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    req_id_e           mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign pop_id  = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_id;
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-requester memory bus arbiter: picks one request per cycle for the single
// downstream port and routes in-order responses back by a registered ID FIFO.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_OUTST = MAX_OUTST_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                set_programming_mode,
    input  logic                set_debug_mode,
    input  logic                m0_req_i,
    output logic                m0_gnt_o,
    input  logic [ADDR_W-1:0]   m0_addr_i,
    input  logic                m0_we_i,
    input  logic [DATA_W/8-1:0] m0_be_i,
    input  logic [DATA_W-1:0]   m0_wdata_i,
    output logic                m0_rvalid_o,
    output logic                m0_err_o,
    output logic [DATA_W-1:0]   m0_rdata_o,
    input  logic                m1_req_i,
    output logic                m1_gnt_o,
    input  logic [ADDR_W-1:0]   m1_addr_i,
    input  logic                m1_we_i,
    input  logic [DATA_W/8-1:0] m1_be_i,
    input  logic [DATA_W-1:0]   m1_wdata_i,
    output logic                m1_rvalid_o,
    output logic                m1_err_o,
    output logic [DATA_W-1:0]   m1_rdata_o,
    output logic                s_req_o,
    output logic [ADDR_W-1:0]   s_addr_o,
    output logic                s_we_o,
    output logic [DATA_W/8-1:0] s_be_o,
    output logic [DATA_W-1:0]   s_wdata_o,
    input  logic                s_gnt_i,
    input  logic                s_rvalid_i,
    input  logic                s_err_i,
    input  logic [DATA_W-1:0]   s_rdata_i,
    output logic                proto_err_o
);

    arb_mode_e mode;
    req_id_e   winner;
    req_id_e   rr_last;
    req_id_e   head_id;
    logic      win_req;
    logic      full;
    logic      empty;
    logic      handshake;
    logic      pop;

    assign mode = arb_mode(set_programming_mode, set_debug_mode);

    always_comb begin
        winner  = REQ_VPROC;
        win_req = 1'b0;
        case (mode)
            ARB_PROG: begin
                winner  = REQ_PROG;
                win_req = m1_req_i;
            end
            ARB_DEBUG: begin
                winner  = m1_req_i ? REQ_PROG : REQ_VPROC;
                win_req = m0_req_i | m1_req_i;
            end
            default: begin
                if (m0_req_i && m1_req_i)
                    winner = (rr_last == REQ_PROG) ? REQ_VPROC : REQ_PROG;
                else
                    winner = m1_req_i ? REQ_PROG : REQ_VPROC;
                win_req = m0_req_i | m1_req_i;
            end
        endcase
    end

    // full is registered, so a same-cycle pop never opens the grant path.
    assign s_req_o   = win_req & ~full;
    assign s_addr_o  = (winner == REQ_PROG) ? m1_addr_i  : m0_addr_i;
    assign s_we_o    = (winner == REQ_PROG) ? m1_we_i    : m0_we_i;
    assign s_be_o    = (winner == REQ_PROG) ? m1_be_i    : m0_be_i;
    assign s_wdata_o = (winner == REQ_PROG) ? m1_wdata_i : m0_wdata_i;

    assign handshake = s_req_o & s_gnt_i;
    assign m0_gnt_o  = handshake & (winner == REQ_VPROC);
    assign m1_gnt_o  = handshake & (winner == REQ_PROG);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_last     <= REQ_PROG;
            proto_err_o <= 1'b0;
        end else begin
            if (handshake && mode == ARB_RR) rr_last <= winner;
            if (s_rvalid_i && empty)         proto_err_o <= 1'b1;
        end
    end

    id_fifo #(
        .DEPTH (MAX_OUTST)
    ) u_id_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (handshake),
        .push_id (winner),
        .pop     (pop),
        .pop_id  (head_id),
        .full    (full),
        .empty   (empty)
    );

    assign pop         = s_rvalid_i & ~empty;
    assign m0_rvalid_o = pop & (head_id == REQ_VPROC);
    assign m1_rvalid_o = pop & (head_id == REQ_PROG);
    assign m0_err_o    = m0_rvalid_o & s_err_i;
    assign m1_err_o    = m1_rvalid_o & s_err_i;
    assign m0_rdata_o  = m0_rvalid_o ? s_rdata_i : '0;
    assign m1_rdata_o  = m1_rvalid_o ? s_rdata_i : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: arbitration modes, FIFO full, response
// routing, protocol error and mid-operation reset.
module tb_mem_bus_arbiter;

    localparam logic [31:0] MASK = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        prog_mode, dbg_mode;
    logic        m0_req, m1_req, m0_gnt, m1_gnt;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic        m0_we, m1_we;
    logic [3:0]  m0_be, m1_be;
    logic        m0_rvalid, m1_rvalid, m0_err, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_req, s_we, s_gnt, s_rvalid, s_err;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_be;
    logic        proto_err;

    logic        auto_resp, man_rvalid;
    logic [31:0] man_rdata;
    logic [1:0]  pv;
    logic [31:0] pd0, pd1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Downstream model: accepts every request, answers 2 cycles later with addr^MASK.
    always @(posedge clk) begin
        if (auto_resp) begin
            pv  <= {pv[0], s_req & s_gnt};
            pd0 <= s_addr ^ MASK;
            pd1 <= pd0;
        end else begin
            pv <= 2'b00;
        end
    end

    assign s_rvalid = auto_resp ? pv[1] : man_rvalid;
    assign s_rdata  = auto_resp ? pd1   : man_rdata;

    mem_bus_arbiter #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .MAX_OUTST (4)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .set_programming_mode (prog_mode),
        .set_debug_mode       (dbg_mode),
        .m0_req_i             (m0_req),
        .m0_gnt_o             (m0_gnt),
        .m0_addr_i            (m0_addr),
        .m0_we_i              (m0_we),
        .m0_be_i              (m0_be),
        .m0_wdata_i           (m0_wdata),
        .m0_rvalid_o          (m0_rvalid),
        .m0_err_o             (m0_err),
        .m0_rdata_o           (m0_rdata),
        .m1_req_i             (m1_req),
        .m1_gnt_o             (m1_gnt),
        .m1_addr_i            (m1_addr),
        .m1_we_i              (m1_we),
        .m1_be_i              (m1_be),
        .m1_wdata_i           (m1_wdata),
        .m1_rvalid_o          (m1_rvalid),
        .m1_err_o             (m1_err),
        .m1_rdata_o           (m1_rdata),
        .s_req_o              (s_req),
        .s_addr_o             (s_addr),
        .s_we_o               (s_we),
        .s_be_o               (s_be),
        .s_wdata_o            (s_wdata),
        .s_gnt_i              (s_gnt),
        .s_rvalid_i           (s_rvalid),
        .s_err_i              (s_err),
        .s_rdata_i            (s_rdata),
        .proto_err_o          (proto_err)
    );

    task automatic test_reset();
        rst = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, s_req, proto_err} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 00000000",
                     {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, s_req, proto_err});
        end
        n_checks++;
        if ({m0_rdata, m1_rdata} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h %h want 0 0", m0_rdata, m1_rdata);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_addr [10];
        int unsigned n0 = 0, n1 = 0;
        logic        exp_rv0, exp_rv1;
        logic [31:0] exp_d;
        auto_resp = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            m0_req  = (c < 8);
            m1_req  = (c < 8);
            m0_addr = 32'h1000 + 4 * n0;
            m1_addr = 32'h2000 + 4 * n1;
            exp_addr[c] = (c % 2 == 0) ? m0_addr : m1_addr;
            #1;
            n_checks++;
            if ({m0_gnt, m1_gnt} !== ((c >= 8) ? 2'b00 : (c % 2 == 0) ? 2'b10 : 2'b01)) begin
                n_fail++;
                $display("FAIL rr_gnt c=%0d: got %b%b", c, m0_gnt, m1_gnt);
            end
            exp_rv0 = (c >= 2) && ((c - 2) % 2 == 0);
            exp_rv1 = (c >= 2) && ((c - 2) % 2 == 1);
            exp_d   = (c >= 2) ? (exp_addr[c-2] ^ MASK) : 32'h0;
            if (c >= 2) begin
                n_checks++;
                if ({m0_rvalid, m1_rvalid} !== {exp_rv0, exp_rv1} ||
                    m0_rdata !== (exp_rv0 ? exp_d : 32'h0) ||
                    m1_rdata !== (exp_rv1 ? exp_d : 32'h0)) begin
                    n_fail++;
                    $display("FAIL rr_resp c=%0d: rv=%b%b d0=%h d1=%h want rv=%b%b d=%h",
                             c, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, exp_rv0, exp_rv1, exp_d);
                end
            end
            if (c < 8) begin
                if (c % 2 == 0) n0++;
                else            n1++;
            end
        end
    endtask

    task automatic test_debug();
        dbg_mode = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            m0_req = 1'b1;
            m1_req = 1'b1;
            #1;
            n_checks++;
            if ({m0_gnt, m1_gnt} !== 2'b01) begin
                n_fail++;
                $display("FAIL dbg_gnt c=%0d: got %b%b want 01", c, m0_gnt, m1_gnt);
            end
        end
        @(negedge clk);
        dbg_mode = 1'b0;
        #1;
        n_checks++;
        if ({m0_gnt, m1_gnt} !== 2'b10) begin
            n_fail++;
            $display("FAIL dbg_exit_gnt: got %b%b want 10", m0_gnt, m1_gnt);
        end
        @(negedge clk);
        m0_req = 1'b0;
        m1_req = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_programming();
        prog_mode = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            m0_req = 1'b1;
            #1;
            n_checks++;
            if ({s_req, m0_gnt} !== 2'b00) begin
                n_fail++;
                $display("FAIL prog_block c=%0d: s_req=%b m0_gnt=%b want 0 0", c, s_req, m0_gnt);
            end
        end
        @(negedge clk);
        m1_req = 1'b1;
        #1;
        n_checks++;
        if ({s_req, m0_gnt, m1_gnt} !== 3'b101) begin
            n_fail++;
            $display("FAIL prog_m1_gnt: got %b%b%b want 101", s_req, m0_gnt, m1_gnt);
        end
        @(negedge clk);
        m0_req = 1'b0;
        m1_req = 1'b0;
        prog_mode = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_full();
        auto_resp = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            m0_req     = 1'b1;
            m0_addr    = 32'h3000;
            man_rvalid = (c == 6);
            man_rdata  = 32'hCAFE_0006;
            #1;
            n_checks++;
            if (m0_gnt !== (c < 4 || c == 7)) begin
                n_fail++;
                $display("FAIL full_gnt c=%0d: got %b want %b", c, m0_gnt, (c < 4 || c == 7));
            end
            if (c == 6) begin
                n_checks++;
                if ({m0_rvalid, m0_rdata} !== {1'b1, 32'hCAFE_0006}) begin
                    n_fail++;
                    $display("FAIL full_pop_resp: rv=%b d=%h want 1 cafe0006", m0_rvalid, m0_rdata);
                end
            end
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            m0_req     = 1'b0;
            man_rvalid = 1'b1;
            man_rdata  = 32'h5A00 + c;
            s_err      = (c == 2);
            #1;
            n_checks++;
            if ({m0_rvalid, m1_rvalid, m0_err} !== {2'b10, (c == 2)} || m0_rdata !== 32'h5A00 + c) begin
                n_fail++;
                $display("FAIL full_drain c=%0d: rv=%b%b err=%b d=%h", c, m0_rvalid, m1_rvalid, m0_err, m0_rdata);
            end
        end
        @(negedge clk);
        man_rvalid = 1'b0;
        s_err      = 1'b0;
    endtask

    task automatic test_proto_err();
        @(negedge clk);
        man_rvalid = 1'b1;
        #1;
        n_checks++;
        if ({m0_rvalid, m1_rvalid, proto_err} !== 3'b000) begin
            n_fail++;
            $display("FAIL proto_drop: got %b%b%b want 000", m0_rvalid, m1_rvalid, proto_err);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            man_rvalid = 1'b0;
            #1;
            n_checks++;
            if (proto_err !== 1'b1) begin
                n_fail++;
                $display("FAIL proto_sticky c=%0d: got %b want 1", c, proto_err);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (proto_err !== 1'b0) begin
            n_fail++;
            $display("FAIL proto_clear: got %b want 0", proto_err);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset_midop();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            m0_req = 1'b1;
            #1;
            n_checks++;
            if (m0_gnt !== 1'b1) begin
                n_fail++;
                $display("FAIL midop_gnt c=%0d: got %b want 1", c, m0_gnt);
            end
        end
        @(negedge clk);
        m0_req = 1'b0;
        rst    = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            man_rvalid = 1'b1;
            #1;
            n_checks++;
            if ({m0_rvalid, m1_rvalid} !== 2'b00) begin
                n_fail++;
                $display("FAIL midop_drop c=%0d: got %b%b want 00", c, m0_rvalid, m1_rvalid);
            end
        end
        @(negedge clk);
        man_rvalid = 1'b0;
        m1_req     = 1'b1;
        m1_addr    = 32'h4000;
        #1;
        n_checks++;
        if ({proto_err, m1_gnt, s_addr} !== {2'b11, 32'h4000}) begin
            n_fail++;
            $display("FAIL midop_resume: perr=%b gnt=%b addr=%h want 1 1 4000", proto_err, m1_gnt, s_addr);
        end
        @(negedge clk);
        m1_req     = 1'b0;
        man_rvalid = 1'b1;
        man_rdata  = 32'hBEEF_0001;
        #1;
        n_checks++;
        if ({m0_rvalid, m1_rvalid, m1_rdata} !== {2'b01, 32'hBEEF_0001}) begin
            n_fail++;
            $display("FAIL midop_resp: rv=%b%b d=%h want 01 beef0001", m0_rvalid, m1_rvalid, m1_rdata);
        end
        @(negedge clk);
        man_rvalid = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        prog_mode = 1'b0;
        dbg_mode = 1'b0;
        m0_req = 1'b0;  m1_req = 1'b0;
        m0_addr = '0;   m1_addr = '0;
        m0_we = 1'b0;   m1_we = 1'b1;
        m0_be = 4'hF;   m1_be = 4'h3;
        m0_wdata = '0;  m1_wdata = '0;
        s_gnt = 1'b1;   s_err = 1'b0;
        auto_resp = 1'b0;
        man_rvalid = 1'b0;
        man_rdata = '0;
        test_reset();
        test_round_robin();
        test_debug();
        test_programming();
        test_full();
        test_proto_err();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
